// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops the data-memory write bus and checks it against a programmed
// table of expected (address, data) writes, reporting pass / fail / timeout.
module mem_write_checker #(
    parameter int N       = 32,
    parameter int DEPTH   = 4,
    parameter int IW      = 2,
    parameter int TIMEOUT = 1000,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ordered,
    input  logic          cfg_we,
    input  logic [IW-1:0] cfg_idx,
    input  logic [N-1:0]  cfg_addr,
    input  logic [N-1:0]  cfg_data,
    input  logic [IW:0]   cfg_count,
    input  logic          start,
    input  logic          memwrite,
    input  logic [N-1:0]  dataadr,
    input  logic [N-1:0]  writedata,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timed_out,
    output logic [IW:0]   match_count,
    output logic [N-1:0]  err_addr,
    output logic [N-1:0]  err_data,
    output logic [CW-1:0] cycles
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_PASS    = 3'd2;
    localparam logic [2:0] S_FAIL    = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    logic [2:0]       state;
    logic [N-1:0]     tab_addr [DEPTH];
    logic [N-1:0]     tab_data [DEPTH];
    logic [DEPTH-1:0] hit;
    logic [IW-1:0]    ptr;
    logic [IW:0]      count_q;
    logic             ord_q;
    logic             hit_now, fail_now, last_hit;
    logic [IW-1:0]    hit_idx;

    assign busy      = state == S_RUN;
    assign pass      = state == S_PASS;
    assign timed_out = state == S_TIMEOUT;
    assign done      = pass || timed_out || state == S_FAIL;

    // Unordered search runs high to low so the lowest matching unhit index wins.
    always_comb begin
        hit_now  = 1'b0;
        fail_now = 1'b0;
        hit_idx  = ptr;
        if (ord_q) begin
            if (memwrite && dataadr == tab_addr[ptr]) begin
                hit_now  = writedata == tab_data[ptr];
                fail_now = writedata != tab_data[ptr];
            end
        end else begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (memwrite && !hit[i] && (IW+1)'(i) < count_q && dataadr == tab_addr[i]) begin
                    if (writedata == tab_data[i]) begin
                        hit_now = 1'b1;
                        hit_idx = IW'(i);
                    end else begin
                        fail_now = 1'b1;
                    end
                end
            end
            fail_now = fail_now && !hit_now;
        end
        last_hit = hit_now && (match_count + (IW+1)'(1)) == count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            hit         <= '0;
            ptr         <= '0;
            count_q     <= '0;
            ord_q       <= 1'b0;
            match_count <= '0;
            err_addr    <= '0;
            err_data    <= '0;
            cycles      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tab_addr[i] <= '0;
                tab_data[i] <= '0;
            end
        end else begin
            if (cfg_we && state != S_RUN && 32'(cfg_idx) < DEPTH) begin
                tab_addr[cfg_idx] <= cfg_addr;
                tab_data[cfg_idx] <= cfg_data;
            end
            if (start && state != S_RUN) begin
                state       <= S_RUN;
                cycles      <= '0;
                match_count <= '0;
                hit         <= '0;
                ptr         <= '0;
                err_addr    <= '0;
                err_data    <= '0;
                ord_q       <= ordered;
                count_q     <= cfg_count > (IW+1)'(DEPTH) ? (IW+1)'(DEPTH) : cfg_count;
            end else if (state == S_RUN) begin
                cycles <= cycles + 1'b1;
                if (match_count == count_q) begin
                    state <= S_PASS;
                end else if (fail_now) begin
                    state    <= S_FAIL;
                    err_addr <= dataadr;
                    err_data <= writedata;
                end else begin
                    if (hit_now) begin
                        hit[hit_idx] <= 1'b1;
                        ptr          <= ptr + 1'b1;
                        match_count  <= match_count + 1'b1;
                    end
                    // A completing match on the last allowed cycle beats the watchdog.
                    if (last_hit)
                        state <= S_PASS;
                    else if (cycles == CW'(TIMEOUT - 1))
                        state <= S_TIMEOUT;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed scoreboard bench for mem_write_checker.
module tb_mem_write_checker;
    localparam int N = 32, DEPTH = 4, IW = 2, TO = 20, CW = 16;

    logic          clk = 0, reset = 0, ordered = 0, cfg_we = 0, start = 0, memwrite = 0;
    logic [IW-1:0] cfg_idx = '0;
    logic [N-1:0]  cfg_addr = '0, cfg_data = '0, dataadr = '0, writedata = '0;
    logic [IW:0]   cfg_count = '0;
    logic          busy, done, pass, timed_out;
    logic [IW:0]   match_count;
    logic [N-1:0]  err_addr, err_data;
    logic [CW-1:0] cycles;

    mem_write_checker #(.N(N), .DEPTH(DEPTH), .IW(IW), .TIMEOUT(TO), .CW(CW)) dut (
        .clk(clk), .reset(reset), .ordered(ordered), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count), .start(start),
        .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata), .busy(busy),
        .done(done), .pass(pass), .timed_out(timed_out), .match_count(match_count),
        .err_addr(err_addr), .err_data(err_data), .cycles(cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pass;
        logic          to;
        logic [N-1:0]  ea;
        logic [N-1:0]  ed;
        logic [IW:0]   mc;
        logic [CW-1:0] cyc;
    } res_t;

    res_t sb[$];
    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [IW-1:0] idx, input logic [N-1:0] a, input logic [N-1:0] d);
        cfg_we = 1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
        cyc();
        cfg_we = 0;
    endtask

    task automatic bus(input logic [N-1:0] a, input logic [N-1:0] d);
        memwrite = 1; dataadr = a; writedata = d;
        cyc();
        memwrite = 0;
    endtask

    task automatic go(input logic [IW:0] cnt, input logic ord);
        cfg_count = cnt; ordered = ord; start = 1;
        cyc();
        start = 0;
    endtask

    task automatic expect_res(input logic p, input logic t, input logic [N-1:0] ea,
                              input logic [N-1:0] ed, input logic [IW:0] mc, input logic [CW-1:0] c);
        sb.push_back('{p, t, ea, ed, mc, c});
    endtask

    // Waits (bounded) for termination, then pops the expected outcome and compares.
    task automatic finish_run(input string tag);
        res_t e;
        int k = 0;
        while (!done && k < 40) begin
            cyc();
            k++;
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'(1));
        end else begin
            e = sb.pop_front();
            check({tag, "_pass"}, 64'(pass), 64'(e.pass));
            check({tag, "_timed_out"}, 64'(timed_out), 64'(e.to));
            check({tag, "_err_addr"}, 64'(err_addr), 64'(e.ea));
            check({tag, "_err_data"}, 64'(err_data), 64'(e.ed));
            check({tag, "_match_count"}, 64'(match_count), 64'(e.mc));
            check({tag, "_cycles"}, 64'(cycles), 64'(e.cyc));
            check({tag, "_busy"}, 64'(busy), 64'(0));
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_pass"}, 64'(pass), 64'(0));
        check({tag, "_timed_out"}, 64'(timed_out), 64'(0));
        check({tag, "_match_count"}, 64'(match_count), 64'(0));
        check({tag, "_err"}, {err_addr, err_data}, 64'(0));
        check({tag, "_cycles"}, 64'(cycles), 64'(0));
    endtask

    initial begin
        cyc(); cyc();
        check_idle("reset");
        reset = 1;
        cyc();
        // Ordered pass
        cfg(0, 84, 32'h96);
        cfg(1, 80, 32'h7);
        expect_res(1, 0, 0, 0, 2, 2);
        go(2, 1);
        check("t1_busy", 64'(busy), 64'(1));
        bus(84, 32'h96);
        check("t1_mc1", 64'(match_count), 64'(1));
        check("t1_not_done", 64'(done), 64'(0));
        bus(80, 32'h7);
        check("t1_pass_next", 64'(pass), 64'(1));
        finish_run("t1");
        // Ordered, out-of-order write ignored
        expect_res(1, 0, 0, 0, 2, 3);
        go(2, 1);
        bus(80, 32'h7);
        check("t2_ignored", 64'(match_count), 64'(0));
        bus(84, 32'h96);
        bus(80, 32'h7);
        finish_run("t2");
        // Data mismatch
        expect_res(0, 0, 84, 32'h95, 0, 1);
        go(1, 1);
        bus(84, 32'h95);
        finish_run("t3");
        // Unordered with duplicates
        cfg(0, 84, 1);
        cfg(1, 84, 1);
        cfg(2, 88, 2);
        expect_res(1, 0, 0, 0, 3, 3);
        go(3, 0);
        bus(88, 2);
        check("t4_hit1", 64'(dut.hit), 64'(4'b0100));
        bus(84, 1);
        check("t4_hit2", 64'(dut.hit), 64'(4'b0101));
        bus(84, 1);
        check("t4_hit3", 64'(dut.hit), 64'(4'b0111));
        finish_run("t4");
        // Timeout, then match on the last allowed cycle
        cfg(0, 84, 32'h96);
        expect_res(0, 1, 0, 0, 0, TO);
        go(1, 1);
        finish_run("t5a");
        cyc(); cyc();
        check("t5a_frozen", 64'(cycles), 64'(TO));
        expect_res(1, 0, 0, 0, 1, TO);
        go(1, 1);
        repeat (TO - 1) cyc();
        check("t5b_still_busy", 64'(busy), 64'(1));
        bus(84, 32'h96);
        finish_run("t5b");
        // Zero count, cfg_we ignored in RUN, reset mid-run
        expect_res(1, 0, 0, 0, 0, 1);
        go(0, 1);
        check("t6_busy", 64'(busy), 64'(1));
        cyc();
        check("t6_pass_one", 64'(pass), 64'(1));
        finish_run("t6a");
        expect_res(1, 0, 0, 0, 1, 2);
        go(1, 1);
        cfg(0, 100, 5);
        bus(84, 32'h96);
        finish_run("t6b");
        go(1, 1);
        cyc();
        reset = 0;
        cyc();
        reset = 1;
        check_idle("t6c_abort");
        expect_res(1, 0, 0, 0, 1, 1);
        go(1, 1);
        bus(0, 0);
        finish_run("t6d_wiped");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
